// File: rtl/jtag_mm_pkg.sv
// Shared definitions for the JTAG-to-Avalon write master: FSM states and the
// byte-enable mask used when a session ends on a partial word.
package jtag_mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RX    = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int MAX_BE_W = 8;

  // Enables ceil(nbits/8) low byte lanes; the caller narrows to its own width.
  function automatic logic [MAX_BE_W-1:0] partial_be(input int nbits);
    int nbytes;
    logic [MAX_BE_W-1:0] mask;
    nbytes = (nbits + 7) / 8;
    mask   = '0;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (i < nbytes) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/jtag_mm_fifo.sv
// Synchronous word FIFO with flush. Exposes the head and the entry behind it so
// the write master can present the next beat on the same edge it pops the head.
module jtag_mm_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [WIDTH-1:0] next_data,
  output logic             full,
  output logic             empty,
  output logic             has_next
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign has_next  = (count_q > (AW+1)'(1));
  assign rd_nxt    = rd_ptr_q + AW'(1);
  assign head_data = mem[rd_ptr_q];
  assign next_data = mem[rd_nxt];

  // A push into a full FIFO only lands if the head leaves on the same edge.
  always_comb begin
    do_push  = push & (~full | pop) & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/jtag_mm_write_master.sv
// Packs a synchronised JTAG shift stream LSB-first into DATA_W-bit words, queues
// them, and issues Avalon-MM writes from a per-session start address.
module jtag_mm_write_master
  import jtag_mm_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 25,
  parameter int DEPTH     = 16,
  parameter int ADDR_INCR = 1
) (
  input  logic                Clk,
  input  logic                nReset,
  input  logic                Capture,
  input  logic                Shift_Valid,
  input  logic                Shift_Bit,
  input  logic                Update,
  input  logic [ADDR_W-1:0]   Start_Address,
  output logic [ADDR_W-1:0]   Avalon_Address,
  output logic [DATA_W/8-1:0] Avalon_ByteEnable,
  output logic [DATA_W-1:0]   Avalon_WriteData,
  output logic                Avalon_Write,
  input  logic                Avalon_WaitRequest,
  output logic                Busy,
  output logic                Overflow,
  output logic [ADDR_W-1:0]   Word_Count
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(DATA_W);
  localparam int FW    = DATA_W + BE_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0]   asm_q, asm_d, asm_bit;
  logic [CNT_W:0]      fill;
  logic [ADDR_W-1:0]   addr_q, addr_d, start_q, start_d, count_q, count_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                write_q, write_d, pend_q, pend_d;
  logic                ovf_q, ovf_d, busy_q, busy_d;
  logic                accept, stall, drain_done;
  logic                push, pop, flush, full, empty, has_next;
  logic [FW-1:0]       push_data, head_data, next_data;

  jtag_mm_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
    .clk       (Clk),
    .rst_n     (nReset),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .next_data (next_data),
    .full      (full),
    .empty     (empty),
    .has_next  (has_next)
  );

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    asm_d     = asm_q;
    asm_bit   = asm_q;
    fill      = {1'b0, bitcnt_q};
    addr_d    = addr_q;
    start_d   = start_q;
    count_d   = count_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    write_d   = write_q;
    pend_d    = pend_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    push_data = '0;
    accept    = write_q & ~Avalon_WaitRequest;
    stall     = write_q & Avalon_WaitRequest;

    if (Capture) begin
      // Old-session words are discarded now; a stalled beat finishes at its
      // old address and the new base is loaded on its accept edge.
      state_d  = ST_RX;
      bitcnt_d = '0;
      asm_d    = '0;
      ovf_d    = 1'b0;
      flush    = 1'b1;
      start_d  = Start_Address;
      if (stall) begin
        pend_d = 1'b1;
      end else begin
        write_d = 1'b0;
        addr_d  = Start_Address;
        count_d = '0;
        pend_d  = 1'b0;
      end
    end else begin
      if (state_q == ST_RX) begin
        if (Shift_Valid) begin
          asm_bit[bitcnt_q] = Shift_Bit;
          if (bitcnt_q == CNT_W'(DATA_W-1)) begin
            push      = 1'b1;
            push_data = {{BE_W{1'b1}}, asm_bit};
            bitcnt_d  = '0;
            asm_d     = '0;
            fill      = '0;
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
            asm_d    = asm_bit;
            fill     = {1'b0, bitcnt_q} + (CNT_W+1)'(1);
          end
        end
        if (Update) begin
          if (fill != '0) begin
            push      = 1'b1;
            push_data = {BE_W'(partial_be(int'(fill))), asm_bit};
            bitcnt_d  = '0;
            asm_d     = '0;
          end
          state_d = (push || !empty || write_q) ? ST_DRAIN : ST_IDLE;
        end
      end

      if (accept) begin
        if (pend_q) begin
          write_d = 1'b0;
          addr_d  = start_q;
          count_d = '0;
          pend_d  = 1'b0;
        end else begin
          pop     = 1'b1;
          count_d = count_q + ADDR_W'(1);
          if (ADDR_INCR != 0) addr_d = addr_q + ADDR_W'(1);
          write_d = has_next;
          if (has_next) {be_d, wdata_d} = next_data;
        end
      end else if (!write_q && !empty) begin
        write_d         = 1'b1;
        {be_d, wdata_d} = head_data;
      end

      if (push && full && !pop) ovf_d = 1'b1;
    end

    drain_done = !write_d && !push && (empty || (pop && !has_next));
    if (!Capture && state_q == ST_DRAIN && drain_done) state_d = ST_IDLE;
    busy_d = (state_d != ST_IDLE) | write_d;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      asm_q    <= '0;
      addr_q   <= '0;
      start_q  <= '0;
      count_q  <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      asm_q    <= asm_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      count_q  <= count_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      write_q  <= write_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign Avalon_Address    = addr_q;
  assign Avalon_ByteEnable = be_q;
  assign Avalon_WriteData  = wdata_q;
  assign Avalon_Write      = write_q;
  assign Busy              = busy_q;
  assign Overflow          = ovf_q;
  assign Word_Count        = count_q;

endmodule
